// File: rtl/kl8e_uart_rx.sv
// kl8e_uart_rx: console keyboard receiver, 8N1 LSB first, with a one-character buffer.
// Define KL8E_RX_PARITY_EN for 8E1 framing and the extra parity_err flag.
module kl8e_uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [0:7] rx_data,
    output logic       rx_full,
    output logic       rx_strobe,
    output logic       frame_err,
`ifdef KL8E_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int unsigned DIVISOR = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int unsigned OS_W    = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIVISOR - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  BIT_LAST  = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef KL8E_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBrk
    } state_e;

    logic       rx_meta_q;
    logic       rx_sync_q;
    logic       rx_prev_q;
    logic [1:0] sync_vld_q;

    // rx_prev_q only ever holds a real line sample, so the reset preset of the
    // synchroniser cannot fake a start edge when the line is held low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            sync_vld_q <= 2'b00;
            rx_prev_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            rx_prev_q  <= rx_sync_q & sync_vld_q[1];
        end
    end

    state_e           state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [OS_W-1:0]  tick_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
`ifdef KL8E_RX_PARITY_EN
    logic             par_bad_q;
`endif

    logic tick;
    logic rx_fall;

    assign tick    = (div_cnt_q == DIV_LAST);
    assign rx_fall = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rx_data    <= '0;
            rx_full    <= 1'b0;
            rx_strobe  <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef KL8E_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_strobe <= 1'b0;
            div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;

            if (rx_ack && rx_full) begin
                rx_full <= 1'b0;
                overrun <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (rx_fall) begin
                        state_q    <= StStart;
                        div_cnt_q  <= '0;
                        tick_cnt_q <= '0;
                    end
                end

                StStart: begin
                    if (tick) begin
                        if (tick_cnt_q == HALF_LAST) begin
                            tick_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            state_q    <= rx_sync_q ? StIdle : StData;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

                StData: begin
                    if (tick) begin
                        if (tick_cnt_q == BIT_LAST) begin
                            tick_cnt_q <= '0;
                            shift_q    <= {rx_sync_q, shift_q[7:1]};
                            bit_idx_q  <= bit_idx_q + 1'b1;
                            if (bit_idx_q == 3'd7) begin
`ifdef KL8E_RX_PARITY_EN
                                state_q <= StParity;
`else
                                state_q <= StStop;
`endif
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

`ifdef KL8E_RX_PARITY_EN
                StParity: begin
                    if (tick) begin
                        if (tick_cnt_q == BIT_LAST) begin
                            tick_cnt_q <= '0;
                            par_bad_q  <= (^shift_q) ^ rx_sync_q;
                            state_q    <= StStop;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
`endif

                StStop: begin
                    if (tick) begin
                        if (tick_cnt_q == BIT_LAST) begin
                            tick_cnt_q <= '0;
                            rx_data    <= shift_q;
                            rx_strobe  <= 1'b1;
                            rx_full    <= 1'b1;
                            frame_err  <= ~rx_sync_q;
`ifdef KL8E_RX_PARITY_EN
                            parity_err <= par_bad_q;
`endif
                            // A same-cycle ack consumed the old character, so no overrun.
                            overrun    <= rx_full & ~rx_ack;
                            state_q    <= rx_sync_q ? StIdle : StBrk;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

                StBrk: begin
                    if (rx_sync_q) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_kl8e_uart_rx.sv
// Scoreboard bench for kl8e_uart_rx: expected characters queued as frames are driven.
module tb_kl8e_uart_rx;

    localparam int unsigned CLK_FREQ   = 3_200_000;
    localparam int unsigned BAUD       = 100_000;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int          BIT        = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ack;
    logic [0:7] rx_data;
    logic       rx_full;
    logic       rx_strobe;
    logic       frame_err;
    logic       overrun;
    logic       perr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    always #5 clk = ~clk;

`ifdef KL8E_RX_PARITY_EN
    logic parity_err;
    assign perr = parity_err;
`else
    assign perr = 1'b0;
`endif

    kl8e_uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_full    (rx_full),
        .rx_strobe  (rx_strobe),
        .frame_err  (frame_err),
`ifdef KL8E_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    always @(negedge clk) begin
        if (rx_strobe === 1'b1) got_q.push_back({perr, frame_err, rx_data});
    end

    // Drives one frame; the expected character record goes on the scoreboard first.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        logic pe;
        pe = 1'b0;
`ifdef KL8E_RX_PARITY_EN
        pe = bad_par;
`endif
        exp_q.push_back({pe, ~stop_bit, d});
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef KL8E_RX_PARITY_EN
        rx = (^d) ^ bad_par;
        repeat (BIT) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic get_char(output logic [9:0] got, output logic [9:0] exp);
        got = 'x;
        exp = '0;
        for (int i = 0; i < 20 * BIT && got_q.size() == 0; i++) @(negedge clk);
        if (got_q.size() != 0) got = got_q.pop_front();
        if (exp_q.size() != 0) exp = exp_q.pop_front();
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_data, rx_full, rx_strobe, frame_err, overrun, perr} !== 13'h0)
            $display("FAIL reset_outputs got %h exp 0000",
                     {rx_data, rx_full, rx_strobe, frame_err, overrun, perr});
        else n_pass++;
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        n_checks++;
        if (got_q.size() != 0) $display("FAIL idle_quiet got %0d strobes exp 0", got_q.size());
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [9:0] got, exp;
        send_frame(8'h55, 1'b1, 1'b0);
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL basic_char got %h exp %h", got, exp);
        else n_pass++;
        n_checks++;
        if ({rx_full, frame_err, overrun} !== 3'b100)
            $display("FAIL basic_flags got %b exp 100", {rx_full, frame_err, overrun});
        else n_pass++;
        repeat (2 * BIT) @(negedge clk);
        n_checks++;
        if (got_q.size() != 0) $display("FAIL basic_one_strobe got %0d extra exp 0", got_q.size());
        else n_pass++;
        pulse_ack();
    endtask

    task automatic test_ack();
        logic [9:0] got, exp;
        send_frame(8'hA5, 1'b1, 1'b0);
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL ack_char1 got %h exp %h", got, exp);
        else n_pass++;
        n_checks++;
        if (rx_full !== 1'b1) $display("FAIL ack_full_set got %b exp 1", rx_full);
        else n_pass++;
        pulse_ack();
        n_checks++;
        if (rx_full !== 1'b0) $display("FAIL ack_full_clr got %b exp 0", rx_full);
        else n_pass++;
        send_frame(8'h3C, 1'b1, 1'b0);
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL ack_char2 got %h exp %h", got, exp);
        else n_pass++;
        n_checks++;
        if ({rx_full, overrun} !== 2'b10)
            $display("FAIL ack_clean_load got %b exp 10", {rx_full, overrun});
        else n_pass++;
        pulse_ack();
    endtask

    task automatic test_overrun();
        logic [9:0] got, exp;
        send_frame(8'h41, 1'b1, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0);
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL ovr_char1 got %h exp %h", got, exp);
        else n_pass++;
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL ovr_char2 got %h exp %h", got, exp);
        else n_pass++;
        n_checks++;
        if ({rx_data, rx_full, overrun} !== {8'h42, 2'b11})
            $display("FAIL ovr_flags got %h exp 10b", {rx_data, rx_full, overrun});
        else n_pass++;
        pulse_ack();
        n_checks++;
        if ({rx_full, overrun} !== 2'b00)
            $display("FAIL ovr_ack_clr got %b exp 00", {rx_full, overrun});
        else n_pass++;
        pulse_ack();
        n_checks++;
        if ({rx_data, rx_full, overrun} !== {8'h42, 2'b00})
            $display("FAIL ovr_idle_ack got %h exp 108", {rx_data, rx_full, overrun});
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [9:0] got, exp;
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        n_checks++;
        if (got_q.size() != 0 || rx_full !== 1'b0)
            $display("FAIL glitch_ignored got %0d strobes full %b exp 0 0", got_q.size(), rx_full);
        else n_pass++;
        send_frame(8'h0D, 1'b1, 1'b0);
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL glitch_next_char got %h exp %h", got, exp);
        else n_pass++;
        pulse_ack();
    endtask

    task automatic test_break();
        logic [9:0] got, exp;
        send_frame(8'h7F, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL brk_char got %h exp %h", got, exp);
        else n_pass++;
        n_checks++;
        if (got_q.size() != 0) $display("FAIL brk_no_strobe got %0d extra exp 0", got_q.size());
        else n_pass++;
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        pulse_ack();
        n_checks++;
        if ({rx_full, frame_err} !== 2'b01)
            $display("FAIL brk_ferr_hold got %b exp 01", {rx_full, frame_err});
        else n_pass++;
        send_frame(8'h20, 1'b1, 1'b0);
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL brk_next_char got %h exp %h", got, exp);
        else n_pass++;
        n_checks++;
        if ({rx_full, frame_err} !== 2'b10)
            $display("FAIL brk_ferr_clr got %b exp 10", {rx_full, frame_err});
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] got, exp;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rx_data, rx_full, rx_strobe, frame_err, overrun, perr} !== 13'h0)
            $display("FAIL midrst_outputs got %h exp 0000",
                     {rx_data, rx_full, rx_strobe, frame_err, overrun, perr});
        else n_pass++;
        reset = 1'b0;
        repeat (8 * BIT) @(negedge clk);
        n_checks++;
        if (got_q.size() != 0) $display("FAIL midrst_discard got %0d strobes exp 0", got_q.size());
        else n_pass++;
        send_frame(8'h31, 1'b1, 1'b0);
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL midrst_next_char got %h exp %h", got, exp);
        else n_pass++;
        pulse_ack();
`ifdef KL8E_RX_PARITY_EN
        send_frame(8'h31, 1'b1, 1'b1);
        get_char(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL parity_bad_char got %h exp %h", got, exp);
        else n_pass++;
        n_checks++;
        if (parity_err !== 1'b1) $display("FAIL parity_err_flag got %b exp 1", parity_err);
        else n_pass++;
        pulse_ack();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
